// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, the fetch queue entry type and PC helpers for the
// instruction fetch front end.
//   PC_W        : program counter width (byte address)
//   INS_W       : instruction width
//   QUEUE_DEPTH : default queue depth / cap on queued plus in-flight fetches
package fetch_pkg;

    localparam int unsigned PC_W        = 9;
    localparam int unsigned INS_W       = 32;
    localparam int unsigned QUEUE_DEPTH = 4;
    localparam int unsigned PC_INC      = 4;

    localparam logic [INS_W-1:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] instr;
    } fetch_entry_t;

    // Instructions are word aligned; the two low address bits are forced to 0.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: request/response channel between the fetch unit and the
// instruction memory.
//   imem_req    : fetch request valid           (master -> slave)
//   imem_addr   : fetch byte address            (master -> slave)
//   imem_ready  : request accepted this cycle   (slave -> master)
//   imem_rvalid : response valid, in order      (slave -> master)
//   imem_rdata  : response instruction          (slave -> master)
interface fetch_unit_if;
    import fetch_pkg::*;

    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_ready;
    logic             imem_rvalid;
    logic [INS_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: first-word fall-through queue of fetch entries.
//   clk, reset : clock, synchronous active-high reset
//   push       : write wr_data at the tail
//   pop        : drop the head (ignored when empty)
//   flush      : empty the queue at the next edge; wins over push
//   rd_data    : head entry (contents undefined when empty)
//   occ        : number of valid entries
//   empty/full : occupancy flags
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = QUEUE_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wr_data,
    output fetch_entry_t     rd_data,
    output logic [CNT_W-1:0] occ,
    output logic             empty,
    output logic             full
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_n;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr_n;
    logic [CNT_W-1:0] occ_n;
    logic             do_pop;

    assign empty   = (occ == '0);
    assign full    = (occ == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointer/occupancy next state; DEPTH is a power of 2 so pointers wrap freely.
    always_comb begin
        rd_ptr_n = rd_ptr;
        wr_ptr_n = wr_ptr;
        occ_n    = occ;
        if (flush) begin
            rd_ptr_n = '0;
            wr_ptr_n = '0;
            occ_n    = '0;
        end else begin
            if (push) begin
                wr_ptr_n = wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_n = rd_ptr + PTR_W'(1);
            end
            occ_n = occ + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            rd_ptr <= rd_ptr_n;
            wr_ptr <= wr_ptr_n;
            occ    <= occ_n;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch front end feeding the IF/ID register.
//   clk, reset   : clock, synchronous active-high reset
//   stall        : decode stall, holds the head entry
//   redirect     : branch redirect / flush from EX
//   redirect_pc  : redirect target (low two bits ignored)
//   imem         : instruction memory channel (master side)
//   if_valid     : head entry valid
//   if_pc        : head PC (0 when empty)
//   if_instr     : head instruction (0 when empty)
//   protocol_err : sticky, set by a response with nothing outstanding
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = QUEUE_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    fetch_unit_if.master     imem,
    output logic             if_valid,
    output logic [PC_W-1:0]  if_pc,
    output logic [INS_W-1:0] if_instr,
    output logic             protocol_err
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  fetch_pc_n;
    logic [PC_W-1:0]  resp_pc;
    logic [PC_W-1:0]  resp_pc_n;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_n;
    logic [CNT_W-1:0] discard_cnt;
    logic [CNT_W-1:0] discard_cnt_n;
    logic             protocol_err_n;
    logic [CNT_W-1:0] occ;
    logic             empty;
    logic             full;
    logic             accept;
    logic             rsp_ok;
    logic             rsp_drop;
    logic             push;
    logic             pop;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;

    // Issue only while queued plus in-flight fetches stay below DEPTH, so a
    // response always has room in the queue.
    assign imem.imem_req  = !reset && !redirect &&
                            ((SUM_W'(occ) + SUM_W'(outstanding)) < SUM_W'(DEPTH));
    assign imem.imem_addr = fetch_pc;

    assign accept   = imem.imem_req && imem.imem_ready;
    assign rsp_ok   = imem.imem_rvalid && (outstanding != '0);
    assign rsp_drop = rsp_ok && (discard_cnt != '0);
    assign push     = rsp_ok && (discard_cnt == '0);
    assign pop      = if_valid && !stall;

    assign push_entry = '{pc: resp_pc, instr: imem.imem_rdata};

    assign if_valid = !empty;
    assign if_pc    = if_valid ? head.pc : '0;
    assign if_instr = if_valid ? head.instr : NOP_INSTR;

    // Redirect flushes the queue; a response landing in the same cycle is
    // either dropped against the old discard count or pushed and flushed.
    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (redirect),
        .wr_data (push_entry),
        .rd_data (head),
        .occ     (occ),
        .empty   (empty),
        .full    (full)
    );

    // Counter and PC next state; redirect overrides normal advance.
    always_comb begin
        outstanding_n  = outstanding + CNT_W'(accept) - CNT_W'(rsp_ok);
        discard_cnt_n  = discard_cnt - CNT_W'(rsp_drop);
        fetch_pc_n     = fetch_pc;
        resp_pc_n      = resp_pc;
        protocol_err_n = protocol_err || (imem.imem_rvalid && (outstanding == '0));
        if (accept) begin
            fetch_pc_n = fetch_pc + PC_W'(PC_INC);
        end
        if (push) begin
            resp_pc_n = resp_pc + PC_W'(PC_INC);
        end
        if (redirect) begin
            fetch_pc_n    = align_pc(redirect_pc);
            resp_pc_n     = align_pc(redirect_pc);
            discard_cnt_n = outstanding_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc     <= '0;
            resp_pc      <= '0;
            outstanding  <= '0;
            discard_cnt  <= '0;
            protocol_err <= 1'b0;
        end else begin
            fetch_pc     <= fetch_pc_n;
            resp_pc      <= resp_pc_n;
            outstanding  <= outstanding_n;
            discard_cnt  <= discard_cnt_n;
            protocol_err <= protocol_err_n;
        end
    end

    // The occupancy cap makes a push into a full, non-draining queue impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && full && !pop && !redirect));

endmodule
